// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_pkg: shared state type and bus constants for the memory bus controller
package mem_bus_pkg;
    typedef enum logic [1:0] {VEC_LO, VEC_HI, IDLE, ACCESS} bus_state_t;
    localparam logic       RW_READ      = 1'b1;
    localparam logic       RW_WRITE     = 1'b0;
    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;
endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: datapath request/response, reset vector and memory bus signals
interface mem_bus_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        bus_err;
    logic        vec_valid;
    logic [15:0] vec_pc;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rw;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_ready, rsp_valid, rsp_rdata, bus_err, vec_valid, vec_pc,
               mem_addr, mem_wdata, mem_rw
    );
    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_ready, rsp_valid, rsp_rdata, bus_err, vec_valid, vec_pc,
               mem_addr, mem_wdata, mem_rw
    );
endinterface

// File: rtl/mem_bus_ctrl_wait_timer.sv
// wait_timer: saturating stall counter that flags the cycle an access must give up
module wait_timer #(
    parameter logic [7:0] WAIT_MAX = 8'd15
) (
    input  logic ph1,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);
    logic [7:0] r_cnt;
    // clear on every state entry, count stalled cycles, stick at all-ones
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_inc && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
    end
    // another stalled cycle would bring the count to WAIT_MAX
    assign o_expire = ({1'b0, r_cnt} + 9'd1) >= {1'b0, WAIT_MAX};
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: reset-vector fetch, then one read/write at a time with wait states and timeout
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
    parameter logic [7:0]  WAIT_MAX     = 8'd15
) (
    input  logic          ph1,
    input  logic          reset,
    mem_bus_ctrl_if.slave bus
);
    localparam logic [15:0] VEC_HI_ADDR = RESET_VECTOR + 16'd1;
    bus_state_t  r_state, w_next;
    logic [15:0] r_addr, r_vec;
    logic [7:0]  r_wdata, r_rdata, w_byte;
    logic        r_write, r_rsp_valid, r_bus_err, r_vec_valid;
    logic        w_busy, w_fin, w_tout, w_step, w_expire;

    wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .ph1      (ph1),
        .reset    (reset),
        .i_clr    (w_next != r_state),
        .i_inc    (w_busy && !bus.mem_ready),
        .o_expire (w_expire)
    );

    // state register
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) r_state <= VEC_LO;
        else r_state <= w_next;
    end

    // completion/timeout detection and next state; vector bytes share the access path
    always_comb begin
        w_busy = r_state != IDLE;
        w_fin  = w_busy && bus.mem_ready;
        w_tout = w_busy && !bus.mem_ready && w_expire;
        w_step = w_fin || w_tout;
        w_byte = bus.mem_ready ? bus.mem_rdata : TIMEOUT_DATA;
        w_next = r_state;
        case (r_state)
            VEC_LO:  w_next = w_step ? VEC_HI : VEC_LO;
            VEC_HI:  w_next = w_step ? IDLE : VEC_HI;
            IDLE:    w_next = bus.req_valid ? ACCESS : IDLE;
            default: w_next = w_step ? IDLE : ACCESS;
        endcase
    end

    // request latches, vector register and response registers
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_vec       <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_bus_err   <= 1'b0;
            r_vec_valid <= 1'b0;
        end else begin
            r_rsp_valid <= r_state == ACCESS && w_step;
            r_bus_err   <= r_state == ACCESS && w_tout;
            r_vec_valid <= r_state == VEC_HI && w_step;
            if (r_state == VEC_LO && w_step) r_vec[7:0] <= w_byte;
            if (r_state == VEC_HI && w_step) begin
                r_vec[15:8] <= w_byte;
                r_addr      <= VEC_HI_ADDR;
            end
            if (r_state == IDLE && bus.req_valid) begin
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_write <= bus.req_write;
            end
            if (r_state == ACCESS && w_step && !r_write) r_rdata <= w_byte;
        end
    end

    assign bus.req_ready = r_state == IDLE;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.bus_err   = r_bus_err;
    assign bus.vec_valid = r_vec_valid;
    assign bus.vec_pc    = r_vec;
    assign bus.mem_addr  = r_state == VEC_LO ? RESET_VECTOR : r_state == VEC_HI ? VEC_HI_ADDR : r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_rw    = (r_state == ACCESS && r_write) ? RW_WRITE : RW_READ;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed and random accesses against a request-level memory model
module tb_mem_bus_ctrl;
    localparam int WAIT_MAX = 4;
    logic       ph1 = 1'b0;
    logic       reset;
    int         errs = 0;
    int         checks = 0;
    logic [7:0] mem [65536];
    logic [7:0] exp_rdata;

    mem_bus_ctrl_if bus();
    mem_bus_ctrl #(.RESET_VECTOR(16'hFFFC), .WAIT_MAX(8'(WAIT_MAX))) dut (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus)
    );

    always #5 ph1 = ~ph1;
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset(input logic rdy, input int lat_exp);
        int lat;
        logic [15:0] pc_exp;
        pc_exp = rdy ? {mem[16'hFFFD], mem[16'hFFFC]} : 16'hFFFF;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.mem_ready = rdy;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_bus_err", 32'(bus.bus_err), 0);
        chk("rst_vec_valid", 32'(bus.vec_valid), 0);
        chk("rst_vec_pc", 32'(bus.vec_pc), 0);
        chk("rst_mem_rw", 32'(bus.mem_rw), 1);
        exp_rdata = 8'h00;
        @(negedge ph1);
        reset = 1'b1;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge ph1);
            chk("vec_no_rsp", 32'(bus.rsp_valid), 0);
            chk("vec_no_err", 32'(bus.bus_err), 0);
            if (bus.vec_valid) lat = c;
            else chk("vec_hold_off", 32'(bus.req_ready), 0);
        end
        chk("vec_latency", 32'(lat), 32'(lat_exp));
        chk("vec_pc", 32'(bus.vec_pc), 32'(pc_exp));
        chk("vec_req_ready", 32'(bus.req_ready), 1);
        bus.mem_ready = 1'b0;
        @(negedge ph1);
        chk("vec_pulse", 32'(bus.vec_valid), 0);
        chk("vec_pc_hold", 32'(bus.vec_pc), 32'(pc_exp));
    endtask

    task automatic do_access(input logic wr, input logic [15:0] a, input logic [7:0] d, input int waits);
        int dn;
        logic ok;
        ok = waits < WAIT_MAX;
        dn = ok ? waits + 1 : WAIT_MAX;
        chk("acc_req_ready", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.mem_ready = 1'b0;
        @(negedge ph1);
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 8'($urandom);
        for (int c = 1; c <= dn; c++) begin
            bus.mem_ready = (c == waits + 1);
            chk("acc_mem_addr", 32'(bus.mem_addr), 32'(a));
            chk("acc_mem_rw", 32'(bus.mem_rw), 32'(!wr));
            if (wr) chk("acc_mem_wdata", 32'(bus.mem_wdata), 32'(d));
            chk("acc_busy", 32'(bus.req_ready), 0);
            @(negedge ph1);
            chk("acc_rsp_valid", 32'(bus.rsp_valid), 32'(c == dn));
        end
        bus.mem_ready = 1'b0;
        if (!wr) exp_rdata = ok ? mem[a] : 8'hFF;
        else if (ok) mem[a] = d;
        chk("acc_rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
        chk("acc_bus_err", 32'(bus.bus_err), 32'(!ok));
        chk("acc_done_ready", 32'(bus.req_ready), 1);
        chk("acc_done_rw", 32'(bus.mem_rw), 1);
        @(negedge ph1);
        chk("acc_rsp_pulse", 32'(bus.rsp_valid), 0);
        chk("acc_err_pulse", 32'(bus.bus_err), 0);
    endtask

    initial begin
        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8) ^ 'h5A);
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'hF0;
        mem[16'hF005] = 8'hA5;
        do_reset(1'b1, 2);
        chk("boot_pc", 32'(bus.vec_pc), 32'h0000_F000);
        do_access(1'b0, 16'hF005, 8'h00, 3);
        do_access(1'b1, 16'h0010, 8'h3C, 0);
        do_access(1'b0, 16'h4321, 8'h00, 6);
        do_access(1'b1, 16'h0020, 8'h77, WAIT_MAX);
        do_access(1'b0, 16'h0010, 8'h00, WAIT_MAX - 1);
        chk("write_landed", 32'(bus.rsp_rdata), 32'h3C);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0010;
        @(negedge ph1);
        chk("b2b_busy", 32'(bus.req_ready), 0);
        bus.req_addr  = 16'hF005;
        bus.mem_ready = 1'b1;
        @(negedge ph1);
        chk("b2b_rsp1", 32'(bus.rsp_valid), 1);
        chk("b2b_data1", 32'(bus.rsp_rdata), 32'(mem[16'h0010]));
        chk("b2b_accept", 32'(bus.req_ready), 1);
        @(negedge ph1);
        bus.req_valid = 1'b0;
        chk("b2b_addr2", 32'(bus.mem_addr), 32'hF005);
        chk("b2b_gap", 32'(bus.rsp_valid), 0);
        @(negedge ph1);
        chk("b2b_rsp2", 32'(bus.rsp_valid), 1);
        chk("b2b_data2", 32'(bus.rsp_rdata), 32'(mem[16'hF005]));
        bus.mem_ready = 1'b0;
        @(negedge ph1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h1234;
        @(negedge ph1);
        bus.req_valid = 1'b0;
        @(negedge ph1);
        do_reset(1'b1, 2);
        chk("rerun_pc", 32'(bus.vec_pc), 32'h0000_F000);
        do_reset(1'b0, 2 * WAIT_MAX);
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge ph1);
            do_access(1'($urandom), 16'($urandom), 8'($urandom), int'($urandom_range(0, WAIT_MAX + 1)));
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
